mem_responder: RTL and testbench

//  Memory-side responder for the CPU datapath's MAR/MDR path. Accepts single-word read/write

---
 rtl/mem_pkg.sv | 29 ++
 rtl/sp_ram.sv | 23 ++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared word width, FSM state and operation encodings for mem_responder
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_BAD = 2'd2
    } op_t;

    // Read and write together is an illegal request, not a read-modify-write.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_BAD;
        end else if (wr) begin
            return OP_WR;
        end else begin
            return OP_RD;
        end
    endfunction

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM, read-first, contents not reset
module sp_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word RAM responder for the MAR/MDR path
// Optional write protection of low addresses: MEM_PROTECT_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int LATENCY    = 2,
    parameter int PROT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    op_t               op_q, op_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_dout;
    logic              prot_hit;
    logic              wr_refused;

    assign prot_hit = (32'(addr_q) < PROT_LIMIT);

`ifdef MEM_PROTECT_EN
    assign wr_refused = prot_hit;
`else
    assign wr_refused = 1'b0 & prot_hit;
`endif

    // While idle the RAM reads the live address so a LATENCY=1 read has data at completion.
    assign ram_addr = (state_q == S_BUSY) ? addr_q : addr;

    sp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we & ~clr),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((read || write) && !done_q) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_d    = decode_op(read, write);
                    cnt_d   = CNT_W'(LATENCY - 1);
                    busy_d  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    case (op_q)
                        OP_RD: rdata_d = ram_dout;
                        OP_WR: begin
                            if (wr_refused) begin
                                err_d = 1'b1;
                            end else begin
                                ram_we = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    localparam int ADDR_W  = 9;
    localparam int LATENCY = 2;
    localparam int MAXWAIT = 20;

    logic              clk = 1'b0;
    logic              clr;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .ADDR_W     (ADDR_W),
        .LATENCY    (LATENCY),
        .PROT_LIMIT (16)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .read  (read),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        clr = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Issue one request, drop it after accept, then time the done pulse.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_rdata);
        int n;
        @(negedge clk);
        read = rd; write = wr; addr = a; wdata = d;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        read = 1'b0; write = 1'b0; addr = ~a; wdata = ~d;
        n = 0;
        while (n < MAXWAIT) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_lat"}, 32'(n), 32'(LATENCY));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int first_idx;
        int second_idx;
        int pulses;
        logic saw_done;

        clr = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        txn("wr20", 1'b0, 1'b1, 9'h020, 32'hDEADBEEF, 1'b0, 32'h0);
        txn("wr30", 1'b0, 1'b1, 9'h030, 32'h12345678, 1'b0, 32'h0);
        txn("wr40", 1'b0, 1'b1, 9'h040, 32'hA5A5A5A5, 1'b0, 32'h0);
        txn("wr1ff", 1'b0, 1'b1, 9'h1FF, 32'h5A5A0001, 1'b0, 32'h0);
        txn("rd20a", 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 32'hDEADBEEF);

        do_reset(2);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_rdata", rdata, 32'd0);
        txn("rd20b", 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 32'hDEADBEEF);

        txn("coll30", 1'b1, 1'b1, 9'h030, 32'hFFFF0000, 1'b1, 32'hDEADBEEF);
        txn("rd30", 1'b1, 1'b0, 9'h030, 32'h0, 1'b0, 32'h12345678);
        txn("rd1ff", 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0, 32'h5A5A0001);

        // Held read: one done per accept, next accept only after done has cleared.
        @(negedge clk);
        read = 1'b1; addr = 9'h040;
        first_idx = -1; second_idx = -1; pulses = 0;
        for (int c = 1; c <= 2 * LATENCY + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first_idx < 0) first_idx = c;
                else if (second_idx < 0) second_idx = c;
            end
        end
        @(negedge clk);
        read = 1'b0;
        check("hold_first_done", 32'(first_idx), 32'(1 + LATENCY));
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_gap", 32'(second_idx - first_idx), 32'(LATENCY + 2));
        check("hold_rdata", rdata, 32'hA5A5A5A5);
        repeat (LATENCY + 2) @(posedge clk);

        // Reset one cycle after accepting a write must abort it.
        @(negedge clk);
        write = 1'b1; addr = 9'h040; wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < LATENCY + 3; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        txn("rd40", 1'b1, 1'b0, 9'h040, 32'h0, 1'b0, 32'hA5A5A5A5);

        txn("wr10", 1'b0, 1'b1, 9'h010, 32'h00C0FFEE, 1'b0, 32'hA5A5A5A5);
        txn("rd10", 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 32'h00C0FFEE);
`ifdef MEM_PROTECT_EN
        txn("wr05", 1'b0, 1'b1, 9'h005, 32'hCAFE0005, 1'b1, 32'h00C0FFEE);
        @(negedge clk);
        read = 1'b1; addr = 9'h005;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        repeat (LATENCY) @(posedge clk);
        #1;
        check("rd05_done", 32'(done), 32'd1);
        check("rd05_unwritten", 32'(rdata != 32'hCAFE0005), 32'd1);
`else
        txn("wr05", 1'b0, 1'b1, 9'h005, 32'hCAFE0005, 1'b0, 32'h00C0FFEE);
        txn("rd05", 1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 32'hCAFE0005);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
